// File: rtl/ps2_rx_hist.sv
// ps2_rx_hist: PS/2 keyboard receiver with byte history and seven-segment output.
//
// Synchronises kbclk/kbdata into clk, filters kbclk, and decodes 11-bit frames
// (start, 8 data bits LSB first, odd parity, stop). Accepted bytes are strobed
// out and shifted into a history register, which is shown as hex digits.
//
// Optional build macro PS2_BREAK_FILTER_EN: keeps 8'hF0 break prefixes and the
// byte following them out of the history, so the display shows make codes only.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   kbclk      raw PS/2 clock pin (asynchronous)
//   kbdata     raw PS/2 data pin (asynchronous)
//   byte_valid 1-cycle pulse, byte_data holds a newly accepted byte
//   byte_data  last accepted byte
//   frame_err  1-cycle pulse on parity, stop-bit or timeout error
//   hist       history, [7:0] newest byte, top byte oldest
//   disp       7-bit segment code per nibble of hist, digit k from hist[4k+3:4k]
module ps2_rx_hist #(
    parameter int unsigned DEB_CYCLES  = 8,
    parameter int unsigned HIST_BYTES  = 2,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      kbclk,
    input  logic                      kbdata,
    output logic                      byte_valid,
    output logic [7:0]                byte_data,
    output logic                      frame_err,
    output logic [8*HIST_BYTES-1:0]   hist,
    output logic [14*HIST_BYTES-1:0]  disp
);

    localparam int unsigned HistW = 8 * HIST_BYTES;
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Active-high segments, bit order gfedcba.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        unique case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic              kbclk_s1_q, kbclk_s2_q, kbdata_s1_q, kbdata_s2_q;
    logic              kbclk_f_q, kbclk_f_d;
    logic [7:0]        deb_cnt_q, deb_cnt_d;
    logic              strobe;
    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_ok_q, par_ok_d;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        byte_data_q, byte_data_d;
    logic [HistW-1:0]  hist_q, hist_d;
`ifdef PS2_BREAK_FILTER_EN
    logic              break_pending_q, break_pending_d;
`endif

    // Filtered clock follows the synchronised level only after it has differed
    // for DEB_CYCLES consecutive cycles; any return to agreement restarts.
    always_comb begin
        kbclk_f_d = kbclk_f_q;
        deb_cnt_d = '0;
        if (kbclk_s2_q != kbclk_f_q) begin
            if (deb_cnt_q == 8'(DEB_CYCLES - 1)) begin
                kbclk_f_d = kbclk_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 8'd1;
            end
        end
    end

    assign strobe = kbclk_f_q & ~kbclk_f_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        tmo_cnt_d    = '0;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        byte_data_d  = byte_data_q;
        hist_d       = hist_q;
`ifdef PS2_BREAK_FILTER_EN
        break_pending_d = break_pending_q;
`endif
        if (strobe) begin
            unique case (state_q)
                StIdle: begin
                    if (!kbdata_s2_q) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shift_d[bit_cnt_q] = kbdata_s2_q;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_ok_d = ^{shift_q, kbdata_s2_q};
                    state_d  = StStop;
                end
                default: begin
                    state_d = StIdle;
                    if (kbdata_s2_q && par_ok_q) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
`ifdef PS2_BREAK_FILTER_EN
                        if (break_pending_q) begin
                            break_pending_d = 1'b0;
                        end else if (shift_q == 8'hF0) begin
                            break_pending_d = 1'b1;
                        end else begin
                            hist_d = HistW'({hist_q, shift_q});
                        end
`else
                        hist_d = HistW'({hist_q, shift_q});
`endif
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != StIdle) begin
            if (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1)) begin
                state_d     = StIdle;
                frame_err_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbclk_s1_q   <= 1'b1;
            kbclk_s2_q   <= 1'b1;
            kbdata_s1_q  <= 1'b1;
            kbdata_s2_q  <= 1'b1;
            kbclk_f_q    <= 1'b1;
            deb_cnt_q    <= '0;
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            tmo_cnt_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            byte_data_q  <= '0;
            hist_q       <= '0;
`ifdef PS2_BREAK_FILTER_EN
            break_pending_q <= 1'b0;
`endif
        end else begin
            kbclk_s1_q   <= kbclk;
            kbclk_s2_q   <= kbclk_s1_q;
            kbdata_s1_q  <= kbdata;
            kbdata_s2_q  <= kbdata_s1_q;
            kbclk_f_q    <= kbclk_f_d;
            deb_cnt_q    <= deb_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            tmo_cnt_q    <= tmo_cnt_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            byte_data_q  <= byte_data_d;
            hist_q       <= hist_d;
`ifdef PS2_BREAK_FILTER_EN
            break_pending_q <= break_pending_d;
`endif
        end
    end

    always_comb begin
        disp = '0;
        for (int k = 0; k < 2 * HIST_BYTES; k++) begin
            disp[7*k +: 7] = hex7(hist_q[4*k +: 4]);
        end
    end

    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign byte_data  = byte_data_q;
    assign hist       = hist_q;

endmodule

// File: tb/tb_ps2_rx_hist.sv
// Directed testbench for ps2_rx_hist with shortened kbclk period and timeout.
module tb_ps2_rx_hist;

    localparam int unsigned DEB  = 8;
    localparam int unsigned HB   = 2;
    localparam int unsigned TMO  = 3000;
    localparam int          HALF = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          kbclk = 1'b1;
    logic          kbdata = 1'b1;
    logic          byte_valid, frame_err;
    logic [7:0]    byte_data;
    logic [15:0]   hist;
    logic [27:0]   disp;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt = 0, ecnt = 0, both = 0;
    logic [7:0] last_byte = 8'h00;

    ps2_rx_hist #(.DEB_CYCLES(DEB), .HIST_BYTES(HB), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .kbclk      (kbclk),
        .kbdata     (kbdata),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .hist       (hist),
        .disp       (disp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (byte_valid) begin
            vcnt++;
            last_byte = byte_data;
        end
        if (frame_err) ecnt++;
        if (byte_valid && frame_err) both++;
    end

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
        endcase
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives the first n bits of a frame; glitch adds a 2-cycle low pulse to
    // kbclk in the high phase of bit 4.
    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            kbdata = bits[i];
            if (glitch && i == 4) begin
                wait_cyc(30);
                kbclk = 1'b0;
                wait_cyc(2);
                kbclk = 1'b1;
                wait_cyc(HALF - 32);
            end else begin
                wait_cyc(HALF);
            end
            kbclk = 1'b0;
            wait_cyc(HALF);
            kbclk = 1'b1;
        end
        kbdata = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                              input bit glitch);
        logic [10:0] bits;
        bits = {stop, (~^d) ^ bad_par, d, 1'b0};
        send_bits(bits, 11, glitch);
        wait_cyc(20);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        kbclk = 1'b1;
        kbdata = 1'b1;
        rst_n = 1'b0;
        wait_cyc(3);
        n_tests++;
        if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", byte_valid); end
        n_tests++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", frame_err); end
        n_tests++;
        if (byte_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h expected 00", byte_data); end
        n_tests++;
        if (hist !== 16'h0000) begin n_fail++; $display("FAIL rst_hist: got %h expected 0000", hist); end
        n_tests++;
        if (disp !== {4{7'h3F}}) begin n_fail++; $display("FAIL rst_disp: got %h expected %h", disp, {4{7'h3F}}); end
        rst_n = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_good_byte;
        int v0 = vcnt, e0 = ecnt;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL good_valid_cnt: got %0d expected 1", vcnt - v0); end
        n_tests++;
        if (ecnt - e0 !== 0) begin n_fail++; $display("FAIL good_err_cnt: got %0d expected 0", ecnt - e0); end
        n_tests++;
        if (byte_data !== 8'h1C) begin n_fail++; $display("FAIL good_data: got %h expected 1c", byte_data); end
        n_tests++;
        if (hist[7:0] !== 8'h1C) begin n_fail++; $display("FAIL good_hist: got %h expected 1c", hist[7:0]); end
        n_tests++;
        if (disp[6:0] !== 7'h39) begin n_fail++; $display("FAIL good_disp0: got %h expected 39", disp[6:0]); end
        n_tests++;
        if (disp[13:7] !== 7'h06) begin n_fail++; $display("FAIL good_disp1: got %h expected 06", disp[13:7]); end
    endtask

    task automatic test_bad_frame(input string name, input bit bad_par, input logic stop);
        int v0 = vcnt, e0 = ecnt;
        send_frame(8'h1C, bad_par, stop, 1'b0);
        n_tests++;
        if (ecnt - e0 !== 1) begin n_fail++; $display("FAIL %s_err_cnt: got %0d expected 1", name, ecnt - e0); end
        n_tests++;
        if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL %s_valid_cnt: got %0d expected 0", name, vcnt - v0); end
        n_tests++;
        if (hist !== 16'h001C) begin n_fail++; $display("FAIL %s_hist: got %h expected 001c", name, hist); end
    endtask

    task automatic test_timeout;
        int v0 = vcnt, e0 = ecnt;
        logic [10:0] bits;
        bits = {1'b1, 1'b0, 8'h5A, 1'b0};
        send_bits(bits, 5, 1'b0);
        n_tests++;
        if (ecnt - e0 !== 0) begin n_fail++; $display("FAIL tmo_early_err: got %0d expected 0", ecnt - e0); end
        wait_cyc(TMO + 100);
        n_tests++;
        if (ecnt - e0 !== 1) begin n_fail++; $display("FAIL tmo_err_cnt: got %0d expected 1", ecnt - e0); end
        n_tests++;
        if (hist !== 16'h001C) begin n_fail++; $display("FAIL tmo_hist: got %h expected 001c", hist); end
        send_frame(8'h32, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL tmo_next_valid: got %0d expected 1", vcnt - v0); end
        n_tests++;
        if (byte_data !== 8'h32) begin n_fail++; $display("FAIL tmo_next_data: got %h expected 32", byte_data); end
        n_tests++;
        if (ecnt - e0 !== 1) begin n_fail++; $display("FAIL tmo_next_err: got %0d expected 1", ecnt - e0); end
    endtask

    task automatic test_back_to_back;
        int v0 = vcnt, e0 = ecnt;
        logic [27:0] exp_disp;
        send_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 11, 1'b0);
        send_bits({1'b1, ~^8'h32, 8'h32, 1'b0}, 11, 1'b1);
        send_bits({1'b1, ~^8'h21, 8'h21, 1'b0}, 11, 1'b0);
        wait_cyc(20);
        exp_disp = {seg(4'h3), seg(4'h2), seg(4'h2), seg(4'h1)};
        n_tests++;
        if (vcnt - v0 !== 3) begin n_fail++; $display("FAIL b2b_valid_cnt: got %0d expected 3", vcnt - v0); end
        n_tests++;
        if (ecnt - e0 !== 0) begin n_fail++; $display("FAIL b2b_err_cnt: got %0d expected 0", ecnt - e0); end
        n_tests++;
        if (hist !== 16'h3221) begin n_fail++; $display("FAIL b2b_hist: got %h expected 3221", hist); end
        n_tests++;
        if (disp !== exp_disp) begin n_fail++; $display("FAIL b2b_disp: got %h expected %h", disp, exp_disp); end
    endtask

    task automatic test_reset_mid_frame;
        int v0, e0;
        send_bits({1'b1, 1'b0, 8'hFF, 1'b0}, 4, 1'b0);
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);
        v0 = vcnt;
        e0 = ecnt;
        send_frame(8'h21, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL rmf_valid_cnt: got %0d expected 1", vcnt - v0); end
        n_tests++;
        if (ecnt - e0 !== 0) begin n_fail++; $display("FAIL rmf_err_cnt: got %0d expected 0", ecnt - e0); end
        n_tests++;
        if (hist !== 16'h0021) begin n_fail++; $display("FAIL rmf_hist: got %h expected 0021", hist); end
    endtask

    task automatic test_break;
        int v0;
        logic [15:0] exp_h;
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);
        v0 = vcnt;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
`ifdef PS2_BREAK_FILTER_EN
        exp_h = 16'h001C;
`else
        exp_h = 16'hF01C;
`endif
        n_tests++;
        if (vcnt - v0 !== 3) begin n_fail++; $display("FAIL brk_valid_cnt: got %0d expected 3", vcnt - v0); end
        n_tests++;
        if (last_byte !== 8'h1C) begin n_fail++; $display("FAIL brk_last: got %h expected 1c", last_byte); end
        n_tests++;
        if (hist !== exp_h) begin n_fail++; $display("FAIL brk_hist: got %h expected %h", hist, exp_h); end
        send_frame(8'h32, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (hist !== 16'h1C32) begin n_fail++; $display("FAIL brk_after_hist: got %h expected 1c32", hist); end
    endtask

    initial begin
        test_reset;
        test_good_byte;
        test_bad_frame("par", 1'b1, 1'b1);
        test_bad_frame("stop", 1'b0, 1'b0);
        test_timeout;
        test_back_to_back;
        test_reset_mid_frame;
        test_break;
        n_tests++;
        if (both !== 0) begin n_fail++; $display("FAIL valid_err_overlap: got %0d expected 0", both); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
